mpu_result_streamer: RTL and testbench
======================================

# mpu_result_streamer

Reads the 5x5 result matrix and the determinant produced by the MPU operation stage and sends them out as a stream of 32-bit words. Only the active `size`×`size` sub-matrix is sent. It uses a valid/ready handshake toward the host-facing bus. It sits between the MPU datapath and the host read-back path, on the read side of the same interface the operation stage writes.

## Interface
- No parameters; element width fixed at 8 bits, word width at 32 bits, max dimension at 5.
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: capture request; sampled only in IDLE.
- `operation` in 3: opcode of the completed operation; 5 = determinant, all others = matrix result.
- `result` in `MATRIX_5x5` (200): signed elements; element (r,c) at bits [(r*5+c)*8 +: 8].
- `determinant` in `INTEGER_8`: signed determinant.
- `size` in `INTEGER_8`: active dimension; legal values 1..5.
- `out_data` out 32: packed word; byte j = bits [j*8 +: 8].
- `out_valid` out 1: `out_data`/`out_last` valid.
- `out_ready` in 1: consumer accepts the word when high together with `out_valid`.
- `out_last` out 1: final word of the transfer.
- `busy` out 1: high in STREAM.
- `done` out 1: one-cycle pulse after the last handshake.
- `error` out 1: one-cycle pulse on an illegal `size`.

## Operation
- States:
  - IDLE: `busy`=0, `out_valid`=0.
  - STREAM: `busy`=1, `out_valid`=1.
- IDLE with `start`=1:
  - `size` in 1..5: capture `result`, `determinant`, `size` and `operation` into internal registers, clear the word index, go to STREAM.
  - `size`=0 or `size`>5: capture nothing, stay in IDLE, pulse `error` the next cycle.
- Matrix mode (captured op ≠ 5):
  - Word count W = ceil(size²/4): 1, 1, 3, 4, 7 for size 1..5.
  - Linear element index k = r*size + c, row-major over the active region only.
  - Word w, byte j carries the element with k = 4w + j, taken from captured bits [(r*5+c)*8 +: 8].
  - Bytes with k ≥ size² are 0.
- Determinant mode (captured op = 5):
  - W = 1.
  - `out_data` = `determinant` sign-extended to 32 bits.
- Handshake:
  - A word transfers on a cycle where `out_valid`=1 and `out_ready`=1.
  - On transfer the index advances.
  - `out_data` and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- `out_last` is 1 exactly while the word index = W−1.
- Transfer of the last word: go to IDLE and pulse `done` one cycle later.
- `start` is ignored in STREAM. Captured data is unaffected by input changes after capture.
- `out_ready` is ignored while `out_valid`=0.
- `reset`, any state: next cycle is IDLE and every output is 0 (`out_data`, `out_valid`, `out_last`, `busy`, `done`, `error`). Any in-flight transfer is abandoned and no `done` is issued.

## Timing
- `start` at edge N → `out_valid`=1 and first word valid at edge N+1 (1-cycle latency).
- With `out_ready` held high: one word per cycle. Last word is visible on cycle N+W. `done`=1 on cycle N+W+1, and `busy` falls in the same cycle.
- Minimum gap between transfers: `start` is accepted again on the cycle `done` is high. A back-to-back capture lands one cycle after the previous `out_last` handshake.
- `error` is high on cycle N+1 only; `busy` stays 0.
- All outputs are registered; no combinational path from `out_ready` to `out_data`.

## Test plan
- Size 2, op 0: elements (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=−4, `out_ready`=1 → one word 0xFC030201, `out_last`=1, `done` 2 cycles after `start`.
- Size 5, op 4: element k = k+1 → 7 words 0x04030201 … 0x14131211, 0x18171615, final word 0x00000019 with `out_last`=1.
- Size 3, op 2: `out_ready` toggles 1,0,0,1,… → exactly 3 words accepted in order. Data is stable during stalls; words are neither dropped nor duplicated.
- Op 5, `determinant`=−7 → single word 0xFFFFFFF9, `out_last`=1. The matrix contents are ignored.
- `size`=0 and then `size`=6 with `start` → `error` pulses for one cycle each; `out_valid`, `busy` and `done` stay 0.
- Size 4 stream: assert `reset` after the 2nd word → all outputs 0 next cycle and no `done`. A new `start` with size 1 then produces a correct single word.

Source files
------------

// File: rtl/mpu_result_streamer.sv
// Streams the active size x size region of the MPU result matrix (or the sign-extended
// determinant) as 32-bit words over a valid/ready handshake. All outputs are registered.
module mpu_result_streamer (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   operation,
  input  logic [199:0] result,
  input  logic [7:0]   determinant,
  input  logic [7:0]   size,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [2:0] OP_DET = 3'd5;

  state_t         state_q, state_d;
  logic [199:0]   mat_q, mat_d;
  logic [7:0]     det_q, det_d;
  logic [2:0]     size_q, size_d;
  logic           det_mode_q, det_mode_d;
  logic [2:0]     idx_q, idx_d;
  logic [31:0]    out_data_q, out_data_d;
  logic           out_last_q, out_last_d;
  logic           done_q, done_d;
  logic           error_q, error_d;

  logic           size_legal;
  logic           in_det_mode;
  logic [2:0]     idx_inc;

  function automatic logic [2:0] word_count(input logic [2:0] sz, input logic det_mode);
    logic [2:0] cnt;
    cnt = 3'd1;
    if (!det_mode) begin
      case (sz)
        3'd3:    cnt = 3'd3;
        3'd4:    cnt = 3'd4;
        3'd5:    cnt = 3'd7;
        default: cnt = 3'd1;
      endcase
    end
    return cnt;
  endfunction

  // Byte j of word w holds linear element k = 4w+j of the active region; the
  // constant-bound search keeps this a plain mux tree with no divider.
  function automatic logic [31:0] pack_word(input logic [199:0] mat,
                                            input logic [7:0]   det,
                                            input logic [2:0]   sz,
                                            input logic         det_mode,
                                            input logic [2:0]   widx);
    logic [31:0] word;
    int          n;
    int          base;
    word = '0;
    n    = int'(sz);
    base = 4 * int'(widx);
    if (det_mode) begin
      word = {{24{det[7]}}, det};
    end else begin
      for (int j = 0; j < 4; j++) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 5; c++) begin
            if (r < n && c < n && (r * n + c) == (base + j)) begin
              word[j*8 +: 8] = mat[(r*5 + c)*8 +: 8];
            end
          end
        end
      end
    end
    return word;
  endfunction

  assign size_legal  = (size != 8'd0) && (size <= 8'd5);
  assign in_det_mode = (operation == OP_DET);
  assign idx_inc     = idx_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    mat_d      = mat_q;
    det_d      = det_q;
    size_d     = size_q;
    det_mode_d = det_mode_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_legal) begin
            mat_d      = result;
            det_d      = determinant;
            size_d     = size[2:0];
            det_mode_d = in_det_mode;
            idx_d      = 3'd0;
            out_data_d = pack_word(result, determinant, size[2:0], in_det_mode, 3'd0);
            out_last_d = (word_count(size[2:0], in_det_mode) == 3'd1);
            state_d    = STREAM;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            out_data_d = '0;
            out_last_d = 1'b0;
          end else begin
            // Next word is precomputed here so out_data never depends on out_ready combinationally.
            idx_d      = idx_inc;
            out_data_d = pack_word(mat_q, det_q, size_q, det_mode_q, idx_inc);
            out_last_d = (idx_inc == (word_count(size_q, det_mode_q) - 3'd1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      mat_q      <= '0;
      det_q      <= '0;
      size_q     <= '0;
      det_mode_q <= 1'b0;
      idx_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mat_q      <= mat_d;
      det_q      <= det_d;
      size_q     <= size_d;
      det_mode_q <= det_mode_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_mpu_result_streamer.sv
// Directed bench for mpu_result_streamer: a vector table streamed back-to-back,
// then stall, illegal-size and mid-stream reset sequences.
module tb_mpu_result_streamer;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   operation;
  logic [199:0] result;
  logic [7:0]   determinant;
  logic [7:0]   size;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         error;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0]       sz;
    logic [2:0]       op;
    logic [7:0]       det;
    logic [199:0]     mat;
    logic [3:0]       nw;
    logic [6:0][31:0] words;
  } vec_t;

  vec_t vecs[8];
  int   nvec = 0;

  mpu_result_streamer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .operation   (operation),
    .result      (result),
    .determinant (determinant),
    .size        (size),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  out_data, 32'h0);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_last"},  {31'b0, out_last},  32'h0);
    check({tag, "_busy"},  {31'b0, busy},      32'h0);
    check({tag, "_done"},  {31'b0, done},      32'h0);
    check({tag, "_error"}, {31'b0, error},     32'h0);
  endtask

  task automatic add_vec(input logic [7:0] sz, input logic [2:0] op, input logic [7:0] det,
                         input logic [199:0] m, input logic [3:0] nw,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5,
                         input logic [31:0] w6);
    vec_t v;
    v.sz = sz; v.op = op; v.det = det; v.mat = m; v.nw = nw;
    v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3;
    v.words[4] = w4; v.words[5] = w5; v.words[6] = w6;
    vecs[nvec] = v;
    nvec++;
  endtask

  logic [199:0] ramp;
  logic [199:0] m;
  logic [199:0] mat3;

  initial begin
    for (int i = 0; i < 25; i++) ramp[i*8 +: 8] = 8'(i + 1);
    mat3 = {25{8'hEE}};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mat3[(r*5 + c)*8 +: 8] = 8'(16*r + c + 1);

    m = {25{8'hAA}};
    m[0 +: 8] = 8'h01; m[8 +: 8] = 8'h02; m[40 +: 8] = 8'h03; m[48 +: 8] = 8'hFC;
    add_vec(8'd2, 3'd0, 8'h00, m, 4'd1, 32'hFC030201, 0, 0, 0, 0, 0, 0);
    add_vec(8'd5, 3'd4, 8'h00, ramp, 4'd7, 32'h04030201, 32'h08070605, 32'h0C0B0A09,
            32'h100F0E0D, 32'h14131211, 32'h18171615, 32'h00000019);
    add_vec(8'd3, 3'd2, 8'h00, mat3, 4'd3, 32'h11030201, 32'h22211312, 32'h00000023, 0, 0, 0, 0);
    add_vec(8'd3, 3'd5, 8'hF9, ramp, 4'd1, 32'hFFFFFFF9, 0, 0, 0, 0, 0, 0);
    m = {25{8'hAA}};
    m[0 +: 8] = 8'h80;
    add_vec(8'd1, 3'd0, 8'h00, m, 4'd1, 32'h00000080, 0, 0, 0, 0, 0, 0);
    add_vec(8'd4, 3'd1, 8'h00, ramp, 4'd4, 32'h04030201, 32'h09080706, 32'h0E0D0C0B,
            32'h13121110, 0, 0, 0);
    add_vec(8'd1, 3'd5, 8'h64, ramp, 4'd1, 32'h00000064, 0, 0, 0, 0, 0, 0);

    reset = 1'b1; start = 1'b0; operation = 3'd0; result = '0;
    determinant = 8'h00; size = 8'd0; out_ready = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Table: each new start is issued in the cycle done is high (minimum gap).
    for (int v = 0; v < nvec; v++) begin
      size = vecs[v].sz; operation = vecs[v].op; determinant = vecs[v].det;
      result = vecs[v].mat; start = 1'b1; out_ready = 1'b1;
      tick();
      start = 1'b0;
      result = '1; determinant = 8'h11;
      for (int w = 0; w < int'(vecs[v].nw); w++) begin
        check($sformatf("v%0d_w%0d_data", v, w), out_data, vecs[v].words[w]);
        check($sformatf("v%0d_w%0d_last", v, w), {31'b0, out_last},
              {31'b0, (w == int'(vecs[v].nw) - 1)});
        check($sformatf("v%0d_w%0d_valid_busy_done", v, w), {29'b0, out_valid, busy, done},
              32'h6);
        tick();
      end
      check($sformatf("v%0d_done", v), {29'b0, out_valid, busy, done}, 32'h1);
    end
    tick();
    check("table_done_clear", {29'b0, out_valid, busy, done}, 32'h0);

    // Stalled stream: out_ready 1,0,0,1,...; start held and inputs changed after capture.
    begin
      int got = 0;
      int cyc = 0;
      size = 8'd3; operation = 3'd2; result = mat3; start = 1'b1; out_ready = 1'b0;
      tick();
      result = '1; size = 8'd5; operation = 3'd5; determinant = 8'h80;
      while (got < 3 && cyc < 30) begin
        out_ready = (cyc % 3 == 0);
        @(negedge clock);
        check($sformatf("stall_c%0d_valid", cyc), {31'b0, out_valid}, 32'h1);
        check($sformatf("stall_c%0d_data", cyc), out_data, vecs[2].words[got]);
        check($sformatf("stall_c%0d_last", cyc), {31'b0, out_last}, {31'b0, got == 2});
        if (out_ready) begin
          got++;
          if (got == 3) start = 1'b0;
        end
        tick();
        cyc++;
      end
      check("stall_word_count", got, 3);
      check("stall_done", {29'b0, out_valid, busy, done}, 32'h1);
      tick();
      check("stall_after", {29'b0, out_valid, busy, done}, 32'h0);
      out_ready = 1'b1;
    end

    // Illegal sizes.
    for (int t = 0; t < 2; t++) begin
      size = (t == 0) ? 8'd0 : 8'd6; operation = 3'd0; result = ramp; start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("err%0d_pulse", t), {28'b0, error, out_valid, busy, done}, 32'h8);
      tick();
      check($sformatf("err%0d_clear", t), {28'b0, error, out_valid, busy, done}, 32'h0);
    end

    // Reset after the second word of a size-4 stream, then a fresh size-1 transfer.
    size = 8'd4; operation = 3'd1; result = ramp; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("rst_w0", out_data, 32'h04030201);
    tick();
    check("rst_w1", out_data, 32'h09080706);
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    tick();
    check("midreset_no_done", {29'b0, out_valid, busy, done}, 32'h0);
    m = {25{8'hAA}};
    m[0 +: 8] = 8'h7F;
    size = 8'd1; operation = 3'd0; result = m; start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_data", out_data, 32'h0000007F);
    check("post_rst_last", {31'b0, out_last}, 32'h1);
    tick();
    check("post_rst_done", {29'b0, out_valid, busy, done}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
